// File: rtl/key_debounce_repeat.sv
// Key conditioner: per-key 2-flop sync, debounce FSM, hold-to-auto-repeat.
// Ports: CLOCK, RESET(async low), KEY_IN(active-low raw), KEY_PULSE/LEVEL/LONG.
module key_debounce_repeat #(
  parameter int NKEYS        = 3,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int CNT_W        = 26
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [NKEYS-1:0] KEY_IN,
  output logic [NKEYS-1:0] KEY_PULSE,
  output logic [NKEYS-1:0] KEY_LEVEL,
  output logic [NKEYS-1:0] KEY_LONG
);

  typedef enum logic [2:0] {
    IDLE, DB_PRS, PRESSED, REPEAT, DB_REL
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             s1, s2;
    logic             pulse_q, level_q, long_q;
    logic             p;

    assign p = ~s2;
    assign KEY_PULSE[k] = pulse_q;
    assign KEY_LEVEL[k] = level_q;
    assign KEY_LONG[k]  = long_q;

    always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
        st      <= IDLE;
        cnt     <= '0;
        s1      <= 1'b1;
        s2      <= 1'b1;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        s1      <= KEY_IN[k];
        s2      <= s1;
        pulse_q <= 1'b0;
        unique case (st)
          IDLE: begin
            if (p) begin
              st  <= DB_PRS;
              cnt <= '0;
            end
          end
          DB_PRS: begin
            if (!p) begin
              st  <= IDLE;
              cnt <= '0;
            end else if (cnt == DB_LAST) begin
              st      <= PRESSED;
              cnt     <= '0;
              pulse_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          PRESSED: begin
            if (!p) begin
              st  <= DB_REL;
              cnt <= '0;
            end else if (cnt == HLD_LAST) begin
              st      <= REPEAT;
              cnt     <= '0;
              pulse_q <= 1'b1;
              long_q  <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          REPEAT: begin
            if (!p) begin
              st     <= DB_REL;
              cnt    <= '0;
              long_q <= 1'b0;
            end else if (cnt == REP_LAST) begin
              cnt     <= '0;
              pulse_q <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          DB_REL: begin
            // a bounce on release re-arms the hold timer without a pulse
            if (p) begin
              st  <= PRESSED;
              cnt <= '0;
            end else if (cnt == DB_LAST) begin
              st      <= IDLE;
              cnt     <= '0;
              level_q <= 1'b0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            st      <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            long_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
